// File: rtl/beacon_tx.sv
// rtl/beacon_tx.sv - pulsed sine beacon: NCO plus quarter-wave LUT feeding a DAC at a fixed burst cadence
module beacon_tx #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int SAMPLE_RATE    = 5_000_000,
    parameter int TARGET_FREQ    = 457_000,
    parameter int ON_SAMPLES     = 350_000,
    parameter int PERIOD_SAMPLES = 5_000_000,
    parameter int DW             = 12,
    parameter int PHASE_W        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [DW-1:0] dac_sample_o,
    output logic          dac_valid_o,
    output logic          carrier_o,
    output logic          pulse_active_o,
    output logic          pulse_start_o
);
    localparam int DIV  = CLK_FREQ / SAMPLE_RATE;
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW   = (PERIOD_SAMPLES > 1) ? $clog2(PERIOD_SAMPLES) : 1;
    localparam logic [63:0] TW64 =
        ((64'(TARGET_FREQ) << PHASE_W) + 64'(SAMPLE_RATE / 2)) / 64'(SAMPLE_RATE);
    localparam logic [PHASE_W-1:0] TW  = TW64[PHASE_W-1:0];
    localparam logic [DW-1:0]      MID = {1'b1, {(DW-1){1'b0}}};
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = real'((2 ** (DW - 1)) - 1);

    if (CLK_FREQ % SAMPLE_RATE != 0) begin : g_bad_div
        $error("beacon_tx: CLK_FREQ must be an exact multiple of SAMPLE_RATE");
    end
    if (PERIOD_SAMPLES <= ON_SAMPLES) begin : g_bad_period
        $error("beacon_tx: PERIOD_SAMPLES must exceed ON_SAMPLES");
    end

    // Half-bin offset keeps the table symmetric so quadrant mirroring needs no special case at i=0.
    logic [DW-2:0] lut [64];
    for (genvar g = 0; g < 64; g++) begin : g_lut
        localparam real ANG = PI / 2.0 * (real'(g) + 0.5) / 64.0;
        assign lut[g] = (DW-1)'($rtoi(AMP * $sin(ANG) + 0.5));
    end

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t             state_q, state_d;
    logic [DIVW-1:0]    div_q, div_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               carrier_q, carrier_d;
    logic               active_q, active_d;
    logic               start_q, start_d;

    logic          tick;
    logic [1:0]    quad;
    logic [5:0]    idx;
    logic [DW-2:0] mag;
    logic [DW-1:0] sine;
    logic [CW:0]   cnt_inc;

    assign tick    = (div_q == DIVW'(DIV - 1));
    assign quad    = phase_q[PHASE_W-1 -: 2];
    assign idx     = phase_q[PHASE_W-3 -: 6];
    assign mag     = quad[0] ? lut[~idx] : lut[idx];
    assign sine    = quad[1] ? (MID - DW'(mag)) : (MID + DW'(mag));
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        carrier_d = carrier_q;
        active_d  = active_q;
        start_d   = 1'b0;
        if (!en_i) begin
            // Disable takes priority over a coincident tick.
            state_d   = S_IDLE;
            div_d     = '0;
            phase_d   = '0;
            cnt_d     = '0;
            sample_d  = MID;
            carrier_d = 1'b0;
            active_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ON;
                    div_d   = '0;
                    phase_d = '0;
                    cnt_d   = '0;
                end
                S_ON, S_OFF: begin
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        valid_d = 1'b1;
                        cnt_d   = cnt_inc[CW-1:0];
                        if (state_q == S_ON) begin
                            sample_d  = sine;
                            carrier_d = phase_q[PHASE_W-1];
                            active_d  = 1'b1;
                            start_d   = (cnt_q == '0);
                            phase_d   = phase_q + TW;
                            if (cnt_inc == (CW+1)'(ON_SAMPLES)) state_d = S_OFF;
                        end else begin
                            sample_d  = MID;
                            carrier_d = 1'b0;
                            active_d  = 1'b0;
                            if (cnt_inc == (CW+1)'(PERIOD_SAMPLES)) begin
                                state_d = S_ON;
                                phase_d = '0;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            phase_q   <= '0;
            cnt_q     <= '0;
            sample_q  <= MID;
            valid_q   <= 1'b0;
            carrier_q <= 1'b0;
            active_q  <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            carrier_q <= carrier_d;
            active_q  <= active_d;
            start_q   <= start_d;
        end
    end

    assign dac_sample_o   = sample_q;
    assign dac_valid_o    = valid_q;
    assign carrier_o      = carrier_q;
    assign pulse_active_o = active_q;
    assign pulse_start_o  = start_q;
endmodule

// File: tb/tb_beacon_tx.sv
// tb/tb_beacon_tx.sv - scoreboard bench for beacon_tx: cadence, golden samples, abort and reset cases
module tb_beacon_tx;
    localparam int  DIV = 20;
    localparam int  ON  = 4;
    localparam int  PER = 10;
    localparam int  TW  = 392_560_011;
    localparam real PI  = 3.14159265358979323846;

    typedef struct {
        int sample;
        bit start;
        bit active;
        bit carrier;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i, en2;
    logic [11:0] dac_sample_o, sample2;
    logic        dac_valid_o, carrier_o, pulse_active_o, pulse_start_o;
    logic        valid2, carrier2, active2, start2;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_strobes = 0;
    int   n_starts = 0;
    int   first_sample = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    beacon_tx #(
        .CLK_FREQ(100_000_000), .SAMPLE_RATE(5_000_000), .TARGET_FREQ(457_000),
        .ON_SAMPLES(ON), .PERIOD_SAMPLES(PER), .DW(12), .PHASE_W(32)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i),
        .dac_sample_o(dac_sample_o), .dac_valid_o(dac_valid_o), .carrier_o(carrier_o),
        .pulse_active_o(pulse_active_o), .pulse_start_o(pulse_start_o)
    );

    // Default burst and rate parameters, clocked at two clks per sample to keep the run short.
    beacon_tx #(
        .CLK_FREQ(10_000_000), .SAMPLE_RATE(5_000_000), .TARGET_FREQ(457_000),
        .ON_SAMPLES(350_000), .PERIOD_SAMPLES(5_000_000), .DW(12), .PHASE_W(32)
    ) dut_default (
        .clk(clk), .rst(rst), .en_i(en2),
        .dac_sample_o(sample2), .dac_valid_o(valid2), .carrier_o(carrier2),
        .pulse_active_o(active2), .pulse_start_o(start2)
    );

    task automatic check_eq(input string tag, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int lut_ref(input int i);
        real r;
        r = 2047.0 * $sin(PI / 2.0 * (real'(i) + 0.5) / 64.0);
        return $rtoi(r + 0.5);
    endfunction

    function automatic int model_sample(input logic [31:0] ph);
        int i;
        int l;
        i = int'(ph[29:24]);
        case (ph[31:30])
            2'd0:    l = lut_ref(i);
            2'd1:    l = lut_ref(63 - i);
            2'd2:    l = -lut_ref(i);
            default: l = -lut_ref(63 - i);
        endcase
        return 2048 + l;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_sample"}, dac_sample_o, 2048);
        check_eq({tag, "_valid"}, dac_valid_o, 0);
        check_eq({tag, "_carrier"}, carrier_o, 0);
        check_eq({tag, "_active"}, pulse_active_o, 0);
        check_eq({tag, "_start"}, pulse_start_o, 0);
    endtask

    task automatic start_burst(input int nexp, output int k);
        exp_t        e;
        int          p;
        logic [31:0] ph;
        @(posedge clk);
        #1;
        k    = cyc;
        en_i = 1'b1;
        for (int n = 0; n < nexp; n++) begin
            p = n % PER;
            if (p < ON) begin
                ph        = 32'(p) * 32'(TW);
                e.sample  = model_sample(ph);
                e.start   = (p == 0);
                e.active  = 1'b1;
                e.carrier = ph[31];
            end else begin
                e.sample  = 2048;
                e.start   = 1'b0;
                e.active  = 1'b0;
                e.carrier = 1'b0;
            end
            e.cyc = k + 1 + DIV * (n + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && dac_valid_o) begin
            n_strobes++;
            if (pulse_start_o) begin
                n_starts++;
                first_sample = int'(dac_sample_o);
            end
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("strobe_cycle", cyc, e.cyc);
                check_eq("sample", dac_sample_o, e.sample);
                check_eq("pulse_start", pulse_start_o, e.start);
                check_eq("pulse_active", pulse_active_o, e.active);
                check_eq("carrier", carrier_o, e.carrier);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, snap;
        int idx, ncross, ncar, first_cross, last_cross, avg_milli;
        int bad_model, bad_carrier, bad_iv;
        bit neg, prev_neg, prev_car;
        rst = 1'b1;
        en_i = 1'b0;
        en2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // Two and a half burst periods: golden samples, strobe spacing, cadence, phase restart.
        start_burst(25, k);
        wait_drain("cadence", 27 * DIV);
        check_eq("start_count", n_starts, 3);
        check_eq("first_sample", first_sample, 2073);
        en_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("disable");
        snap = n_strobes;
        repeat (3 * DIV) @(posedge clk);
        #1;
        check_eq("idle_quiet", n_strobes, snap);

        // Abort on the second burst sample, then restart cleanly.
        start_burst(2, k);
        wait_drain("abort", 4 * DIV);
        check_eq("abort_pre_active", pulse_active_o, 1);
        en_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("abort");
        snap = n_strobes;
        repeat (3 * DIV) @(posedge clk);
        #1;
        check_eq("abort_quiet", n_strobes, snap);
        snap = n_starts;
        start_burst(3, k);
        wait_drain("restart", 5 * DIV);
        check_eq("restart_starts", n_starts - snap, 1);
        check_eq("restart_first_sample", first_sample, 2073);
        en_i = 1'b0;
        repeat (2) @(posedge clk);

        // Disable sampled on the very edge that would register the second strobe.
        start_burst(1, k);
        while (cyc < k + 2 * DIV) begin
            @(posedge clk);
            #1;
        end
        en_i = 1'b0;
        snap = n_strobes;
        @(posedge clk);
        @(negedge clk);
        check_idle("tick_disable");
        repeat (3 * DIV) @(posedge clk);
        #1;
        check_eq("tick_disable_quiet", n_strobes, snap);
        check_eq("tick_disable_drained", exp_q.size(), 0);

        // Asynchronous reset mid-burst, checked between clock edges.
        start_burst(3, k);
        wait_drain("pre_reset", 5 * DIV);
        check_eq("pre_reset_active", pulse_active_o, 1);
        #2 rst = 1'b1;
        #1;
        check_idle("async_reset");
        en_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Default rate: 10000 samples, bit-exact samples and 457 kHz zero-crossing statistics.
        @(posedge clk);
        #1;
        en2 = 1'b1;
        idx = 0; ncross = 0; ncar = 0; first_cross = 0; last_cross = 0;
        bad_model = 0; bad_carrier = 0; bad_iv = 0;
        prev_neg = 1'b0; prev_car = 1'b0;
        for (int c = 0; c < 25_000 && idx < 10_000; c++) begin
            @(negedge clk);
            if (valid2) begin
                if (int'(sample2) != model_sample(32'(idx) * 32'(TW))) bad_model++;
                neg = (sample2 < 12'd2048);
                if (carrier2 != neg) bad_carrier++;
                if (idx > 0 && neg != prev_neg) begin
                    if (ncross == 0) first_cross = idx;
                    else if (idx - last_cross < 5 || idx - last_cross > 6) bad_iv++;
                    last_cross = idx;
                    ncross++;
                end
                if (idx > 0 && carrier2 != prev_car) ncar++;
                prev_neg = neg;
                prev_car = carrier2;
                idx++;
            end
        end
        en2 = 1'b0;
        avg_milli = (ncross > 1) ? (2000 * (last_cross - first_cross)) / (ncross - 1) : 0;
        check_eq("default_sample_count", idx, 10_000);
        check_eq("default_model_mismatches", bad_model, 0);
        check_eq("default_carrier_vs_sign", bad_carrier, 0);
        check_eq("default_half_period_jitter", bad_iv, 0);
        check_eq("default_crossings_in_range", (ncross >= 1826 && ncross <= 1828), 1);
        check_eq("default_carrier_transitions", ncar, ncross);
        check_eq("default_avg_samples_per_cycle", (avg_milli >= 10_900 && avg_milli <= 10_990), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/beacon_tx.md
# beacon_tx

Transmit-side counterpart of the 457 kHz receive datapath. It generates a pulsed 457 kHz sine beacon as 12-bit offset-binary DAC samples at the same 5 MS/s sample rate the receiver digitises at. Bursts follow a fixed on/off cadence, and each burst starts at a deterministic phase. It sits between system control (`en_i`) and the DAC interface, and also serves as a loopback stimulus source for the receive chain.

## Interface

Parameters:
- `CLK_FREQ`, 100_000_000: system clock in Hz. Must be an exact multiple of `SAMPLE_RATE`; elaboration fails otherwise.
- `SAMPLE_RATE`, 5_000_000: DAC sample rate in Hz.
- `TARGET_FREQ`, 457_000: carrier frequency in Hz.
- `ON_SAMPLES`, 350_000: burst length in samples (70 ms).
- `PERIOD_SAMPLES`, 5_000_000: burst repetition period in samples (1 s). Must be greater than `ON_SAMPLES`.
- `DW`, 12: DAC sample width.
- `PHASE_W`, 32: phase accumulator width.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `en_i`, in, 1: transmit enable, level-sensitive.
- `dac_sample_o`, out, `DW`: offset-binary sample; midscale is 2048.
- `dac_valid_o`, out, 1: one-clk strobe per new sample.
- `carrier_o`, out, 1: square-wave carrier equal to the phase MSB during a burst, else 0.
- `pulse_active_o`, out, 1: high while in ON.
- `pulse_start_o`, out, 1: one-clk strobe on the first sample of each burst.

## Operation

Derived constants:
- `DIV = CLK_FREQ / SAMPLE_RATE`.
- `TW = round(TARGET_FREQ * 2^PHASE_W / SAMPLE_RATE)`; 392_560_011 at the defaults.

Tick divider:
- Counts 0 to `DIV`-1 while enabled; tick is asserted when it equals `DIV`-1.
- Held at 0 in IDLE.

Sine generation:
- Quarter-wave LUT with 64 entries: `L[i] = round(2047 * sin(pi/2 * (i + 0.5) / 64))`. `L[0]` = 25, `L[63]` = 2047.
- Quadrant `q` = phase[31:30]; index `i` = phase[29:24].
- Signed sample `s`: q0 gives +`L[i]`; q1 gives +`L[63-i]`; q2 gives -`L[i]`; q3 gives -`L[63-i]`.
- Output `dac_sample_o` = 2048 + `s`, so the range is 1..4095.

States:
- **IDLE**
  - Outputs midscale, no `dac_valid_o`.
  - `en_i` = 1 moves to ON, clearing phase, the sample counter, and the divider.
- **ON**
  - On each tick: register the sample for the current phase, then add `TW` to the phase (wraps mod 2^32) and increment the sample counter.
  - After `ON_SAMPLES` ticks, go to OFF.
- **OFF**
  - On each tick: emit midscale (2048) with `dac_valid_o`, and keep counting.
  - When the counter reaches `PERIOD_SAMPLES` ticks from burst start, go to ON with phase = 0 and counter = 0.
- **Any state**
  - `en_i` = 0 returns to IDLE on the next clk. This aborts a burst mid-way.
  - Outputs become midscale, and `carrier_o`, `pulse_active_o`, `dac_valid_o` and `pulse_start_o` are 0 from that clk on.

Widths:
- Sample counter is `$clog2(PERIOD_SAMPLES)` bits.
- The `L` values are positive and at most 2047, so 2048 ± `L` never overflows `DW`.

## Timing

Reset values:
- `dac_sample_o` = 2048.
- All other outputs 0.
- State IDLE; phase, counters and divider 0.

Start-up and output registration:
- `en_i` is sampled high at edge E0, and the state is ON after E0.
- The first tick occurs `DIV` clks later. `dac_valid_o` and `pulse_start_o` are high on the clk after the tick, together with `dac_sample_o` = 2073 (q0, `i` = 0).
- `dac_sample_o`, `carrier_o` and `pulse_active_o` are registered on the tick and hold between strobes.
- `dac_valid_o` spacing is exactly `DIV` clks while enabled, including across ON/OFF transitions.
- Burst timing:
  - `pulse_active_o` rises with the first burst strobe.
  - It falls with the first OFF strobe, i.e. strobe number `ON_SAMPLES`+1 counted from burst start.
- The next `pulse_start_o` is exactly `PERIOD_SAMPLES * DIV` clks after the previous one.

Boundary conditions:
- `en_i` toggling 1→0→1 restarts cleanly at phase 0, with the first strobe `DIV` clks after re-enable.
- `rst` asserted mid-burst forces reset values immediately, without waiting for a clk edge.
- `en_i` falling on the same clk as a tick: the disable wins. No strobe is produced and outputs go to midscale.

## Test plan

Use `DIV` = 20, `ON_SAMPLES` = 4, `PERIOD_SAMPLES` = 10 unless stated otherwise.

1. Reset → `dac_sample_o` = 2048, all other outputs 0. Assert `rst` asynchronously mid-burst → same values within the cycle, with no clk edge needed.
2. Raise `en_i` → first `dac_valid_o`/`pulse_start_o` exactly 20 clks later with sample 2073. Strobes then follow every 20 clks; samples match a golden NCO+LUT model bit-exactly.
3. Cadence check → `pulse_active_o` high for 4 strobes, then 6 midscale strobes. `pulse_start_o` repeats every 200 clks and its sample is 2073 each time (phase reset).
4. Default parameters, 10_000 samples → sample sign and `carrier_o` change at 457 kHz ± 1 sample-period jitter, and zero crossings average 5e6/457e3 ≈ 10.94 samples per cycle.
5. Drop `en_i` at the 2nd burst sample → midscale and no strobes from the next clk on. Re-enable → first strobe 20 clks later with value 2073 and `pulse_start_o`.
6. `en_i` falling on a tick cycle → no `dac_valid_o` that cycle or after.
